// File: rtl/decode_out_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_out_queue
// Description : Register-based first-word-fall-through queue that buffers
//               decode bundles (E/Mem/W control, npc, IR) between the decode
//               stage and its consumer. Occupancy is tracked by an explicit
//               counter. The head fields read as zero whenever the queue is
//               empty.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_out_queue #(
   parameter int DATA_WIDTH = 16,
   parameter int E_WIDTH    = 6,
   parameter int W_WIDTH    = 2,
   parameter int DEPTH      = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   // producer side
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [E_WIDTH-1:0]         in_E_control,
   input  logic [DATA_WIDTH-1:0]      in_npc,
   input  logic                       in_Mem_control,
   input  logic [W_WIDTH-1:0]         in_W_control,
   input  logic [DATA_WIDTH-1:0]      in_IR,
   input  logic                       flush,
   // consumer side
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [E_WIDTH-1:0]         E_control,
   output logic [DATA_WIDTH-1:0]      npc_out,
   output logic                       Mem_control,
   output logic [W_WIDTH-1:0]         W_control,
   output logic [DATA_WIDTH-1:0]      IR,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int C_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int C_CW = $clog2(DEPTH + 1);
   localparam int C_BW = E_WIDTH + DATA_WIDTH + 1 + W_WIDTH + DATA_WIDTH;

   // bit offsets of each field inside a packed bundle {E, npc, Mem, W, IR}
   localparam int C_IR_LSB  = 0;
   localparam int C_W_LSB   = C_IR_LSB + DATA_WIDTH;
   localparam int C_MEM_LSB = C_W_LSB + W_WIDTH;
   localparam int C_NPC_LSB = C_MEM_LSB + 1;
   localparam int C_E_LSB   = C_NPC_LSB + DATA_WIDTH;

   localparam logic [C_CW-1:0] C_FULL = C_CW'(DEPTH);
   localparam logic [C_PW-1:0] C_LAST = C_PW'(DEPTH - 1);

   logic [C_BW-1:0] mem_q [DEPTH];
   logic [C_PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [C_PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [C_CW-1:0] count_q, count_d;

   logic            push;
   logic            pop;
   logic [C_BW-1:0] in_bundle;
   logic [C_BW-1:0] head_bundle;

   // Handshake status depends only on registered occupancy, never on the
   // other side's handshake inputs.
   assign in_ready  = (count_q < C_FULL);
   assign out_valid = (count_q != '0);
   assign count     = count_q;

   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign in_bundle = {in_E_control, in_npc, in_Mem_control, in_W_control, in_IR};

   // Next-state for pointers and occupancy; flush overrides any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // One storage register per slot, written only when it is the tail slot.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic we;
      assign we = push & ~flush & (wr_ptr_q == C_PW'(gi));

      // Capture the incoming bundle into this slot.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            mem_q[gi] <= '0;
         end else if (we) begin
            mem_q[gi] <= in_bundle;
         end
      end
   end

   // Head selection as an explicit mux so a non-power-of-two DEPTH never
   // addresses a slot that does not exist.
   always_comb begin
      head_bundle = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_ptr_q == C_PW'(i)) begin
            head_bundle = mem_q[i];
         end
      end
   end

   // Head fields are forced to zero while the queue is empty.
   always_comb begin
      E_control   = '0;
      npc_out     = '0;
      Mem_control = 1'b0;
      W_control   = '0;
      IR          = '0;
      if (out_valid) begin
         E_control   = head_bundle[C_E_LSB   +: E_WIDTH];
         npc_out     = head_bundle[C_NPC_LSB +: DATA_WIDTH];
         Mem_control = head_bundle[C_MEM_LSB];
         W_control   = head_bundle[C_W_LSB   +: W_WIDTH];
         IR          = head_bundle[C_IR_LSB  +: DATA_WIDTH];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decode_out_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_out_queue
// Description : Directed bench for decode_out_queue: a DEPTH=4 instance for
//               fill/full/stream/flush/reset cases and a DEPTH=3 instance
//               driven with random interleaved traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_out_queue;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   // DEPTH=4 instance signals
   logic        d4_in_valid, d4_in_ready, d4_flush, d4_out_valid, d4_out_ready;
   logic [5:0]  d4_in_E, d4_E;
   logic [15:0] d4_in_npc, d4_npc, d4_in_IR, d4_IR;
   logic        d4_in_Mem, d4_Mem;
   logic [1:0]  d4_in_W, d4_W;
   logic [2:0]  d4_count;

   // DEPTH=3 instance signals
   logic        d3_in_valid, d3_in_ready, d3_flush, d3_out_valid, d3_out_ready;
   logic [5:0]  d3_in_E, d3_E;
   logic [15:0] d3_in_npc, d3_npc, d3_in_IR, d3_IR;
   logic        d3_in_Mem, d3_Mem;
   logic [1:0]  d3_in_W, d3_W;
   logic [1:0]  d3_count;

   decode_out_queue #(.DATA_WIDTH(16), .E_WIDTH(6), .W_WIDTH(2), .DEPTH(4)) u_q4 (
      .clock(clock), .reset(reset),
      .in_valid(d4_in_valid), .in_ready(d4_in_ready),
      .in_E_control(d4_in_E), .in_npc(d4_in_npc), .in_Mem_control(d4_in_Mem),
      .in_W_control(d4_in_W), .in_IR(d4_in_IR), .flush(d4_flush),
      .out_valid(d4_out_valid), .out_ready(d4_out_ready),
      .E_control(d4_E), .npc_out(d4_npc), .Mem_control(d4_Mem),
      .W_control(d4_W), .IR(d4_IR), .count(d4_count)
   );

   decode_out_queue #(.DATA_WIDTH(16), .E_WIDTH(6), .W_WIDTH(2), .DEPTH(3)) u_q3 (
      .clock(clock), .reset(reset),
      .in_valid(d3_in_valid), .in_ready(d3_in_ready),
      .in_E_control(d3_in_E), .in_npc(d3_in_npc), .in_Mem_control(d3_in_Mem),
      .in_W_control(d3_in_W), .in_IR(d3_in_IR), .flush(d3_flush),
      .out_valid(d3_out_valid), .out_ready(d3_out_ready),
      .E_control(d3_E), .npc_out(d3_npc), .Mem_control(d3_Mem),
      .W_control(d3_W), .IR(d3_IR), .count(d3_count)
   );

   int passed = 0;
   int total  = 0;

   // side fields derived from IR so every bundle is distinguishable
   function automatic logic [5:0]  e_of(input logic [15:0] ir);   return ir[5:0] ^ 6'h15; endfunction
   function automatic logic [15:0] npc_of(input logic [15:0] ir); return ir ^ 16'h5A5A;    endfunction
   function automatic logic        mem_of(input logic [15:0] ir); return ir[0] ^ ir[4];    endfunction
   function automatic logic [1:0]  w_of(input logic [15:0] ir);   return ir[2:1];          endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_in4(input logic [15:0] ir);
      d4_in_IR  = ir;
      d4_in_E   = e_of(ir);
      d4_in_npc = npc_of(ir);
      d4_in_Mem = mem_of(ir);
      d4_in_W   = w_of(ir);
   endtask

   task automatic set_in3(input logic [15:0] ir);
      d3_in_IR  = ir;
      d3_in_E   = e_of(ir);
      d3_in_npc = npc_of(ir);
      d3_in_Mem = mem_of(ir);
      d3_in_W   = w_of(ir);
   endtask

   task automatic head4(input string tag, input logic [15:0] ir);
      chk({tag, ".valid"}, 32'(d4_out_valid), 32'd1);
      chk({tag, ".IR"},    32'(d4_IR),  32'(ir));
      chk({tag, ".E"},     32'(d4_E),   32'(e_of(ir)));
      chk({tag, ".npc"},   32'(d4_npc), 32'(npc_of(ir)));
      chk({tag, ".Mem"},   32'(d4_Mem), 32'(mem_of(ir)));
      chk({tag, ".W"},     32'(d4_W),   32'(w_of(ir)));
   endtask

   task automatic empty4(input string tag);
      chk({tag, ".count"}, 32'(d4_count),     32'd0);
      chk({tag, ".valid"}, 32'(d4_out_valid), 32'd0);
      chk({tag, ".ready"}, 32'(d4_in_ready),  32'd1);
      chk({tag, ".fields"}, 32'({d4_E, d4_npc, d4_Mem, d4_W} | 41'(d4_IR)), 32'd0);
      chk({tag, ".IR"},    32'(d4_IR), 32'd0);
   endtask

   logic [15:0] sb[$];
   int          pushes;
   logic        v, r, exp_push, exp_pop;

   initial begin
      reset = 1'b1;
      d4_in_valid = 0; d4_out_ready = 0; d4_flush = 0; set_in4(16'h0);
      d3_in_valid = 0; d3_out_ready = 0; d3_flush = 0; set_in3(16'h0);
      step();
      empty4("reset_hold");
      reset = 1'b0;
      step();
      empty4("after_reset");

      // ---- fill to full with consumer stalled ----
      d4_in_valid = 1; d4_out_ready = 0;
      for (int i = 1; i <= 4; i++) begin
         set_in4(16'h1000 + 16'(i));
         if (i == 1) begin
            #1;
            chk("no_bypass.valid", 32'(d4_out_valid), 32'd0);
            chk("no_bypass.IR",    32'(d4_IR), 32'd0);
         end
         step();
         chk($sformatf("fill%0d.count", i), 32'(d4_count), 32'(i));
         head4($sformatf("fill%0d.head", i), 16'h1001);
      end
      chk("full.in_ready", 32'(d4_in_ready), 32'd0);

      // stalled full queue ignores a push and holds its head
      set_in4(16'h1FFF);
      step();
      chk("full_hold.count", 32'(d4_count), 32'd4);
      head4("full_hold.head", 16'h1001);

      // full with push+pop in the same cycle: pop only
      set_in4(16'h2000); d4_out_ready = 1;
      step();
      chk("full_pp.count", 32'(d4_count), 32'd3);
      chk("full_pp.in_ready", 32'(d4_in_ready), 32'd1);
      head4("full_pp.head", 16'h1002);

      // drain; 0x2000 must never appear
      d4_in_valid = 0;
      step(); chk("drain1.count", 32'(d4_count), 32'd2); head4("drain1.head", 16'h1003);
      step(); chk("drain2.count", 32'(d4_count), 32'd1); head4("drain2.head", 16'h1004);
      step(); empty4("drained");
      step(); empty4("empty_pop");

      // ---- streaming: 20 cycles of simultaneous push/pop ----
      d4_in_valid = 1; d4_out_ready = 1;
      for (int j = 0; j < 20; j++) begin
         set_in4(16'(j));
         step();
         chk($sformatf("stream%0d.count", j), 32'(d4_count), 32'd1);
         head4($sformatf("stream%0d.head", j), 16'(j));
      end
      d4_in_valid = 0;
      step();
      empty4("stream_end");

      // ---- flush with concurrent push and pop ----
      d4_out_ready = 0; d4_in_valid = 1;
      for (int i = 1; i <= 3; i++) begin
         set_in4(16'h3000 + 16'(i));
         step();
      end
      chk("pre_flush.count", 32'(d4_count), 32'd3);
      set_in4(16'h3FFF); d4_out_ready = 1; d4_flush = 1;
      step();
      d4_flush = 0; d4_in_valid = 0; d4_out_ready = 0;
      empty4("flushed");
      set_in4(16'h3100); d4_in_valid = 1;
      step();
      d4_in_valid = 0;
      chk("post_flush.count", 32'(d4_count), 32'd1);
      head4("post_flush.head", 16'h3100);
      d4_out_ready = 1;
      step();
      d4_out_ready = 0;
      empty4("post_flush_pop");

      // ---- asynchronous reset between edges ----
      d4_in_valid = 1;
      set_in4(16'h4001); step();
      set_in4(16'h4002); step();
      d4_in_valid = 0;
      chk("pre_reset.count", 32'(d4_count), 32'd2);
      #2 reset = 1'b1;
      #1;
      empty4("async_reset");
      #1 reset = 1'b0;
      step();
      d4_in_valid = 1; d4_in_E = 6'h2A; d4_in_npc = 16'h3005;
      d4_in_IR = 16'h4100; d4_in_Mem = 1'b1; d4_in_W = 2'd2;
      step();
      d4_in_valid = 0;
      chk("rst_push.count", 32'(d4_count),     32'd1);
      chk("rst_push.valid", 32'(d4_out_valid), 32'd1);
      chk("rst_push.E",     32'(d4_E),   32'h2A);
      chk("rst_push.npc",   32'(d4_npc), 32'h3005);
      chk("rst_push.IR",    32'(d4_IR),  32'h4100);
      chk("rst_push.Mem",   32'(d4_Mem), 32'd1);
      chk("rst_push.W",     32'(d4_W),   32'd2);
      d4_out_ready = 1;
      step();
      d4_out_ready = 0;
      empty4("rst_pop");

      // ---- DEPTH=3 random interleave against a queue model ----
      pushes = 0;
      for (int cyc = 0; cyc < 300 && (pushes < 10 || sb.size() > 0); cyc++) begin
         v = (pushes < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
         r = 1'($urandom_range(0, 1));
         d3_in_valid = v; d3_out_ready = r;
         set_in3(16'h5000 + 16'(pushes));
         #1;
         chk("d3.valid", 32'(d3_out_valid), 32'(sb.size() != 0));
         chk("d3.in_ready", 32'(d3_in_ready), 32'(sb.size() < 3));
         if (sb.size() > 0) begin
            chk("d3.IR",  32'(d3_IR),  32'(sb[0]));
            chk("d3.E",   32'(d3_E),   32'(e_of(sb[0])));
            chk("d3.npc", 32'(d3_npc), 32'(npc_of(sb[0])));
            chk("d3.Mem", 32'(d3_Mem), 32'(mem_of(sb[0])));
            chk("d3.W",   32'(d3_W),   32'(w_of(sb[0])));
         end
         exp_push = v && (sb.size() < 3);
         exp_pop  = r && (sb.size() > 0);
         step();
         if (exp_pop) void'(sb.pop_front());
         if (exp_push) begin
            sb.push_back(16'h5000 + 16'(pushes));
            pushes++;
         end
         chk("d3.count", 32'(d3_count), 32'(sb.size()));
      end
      d3_in_valid = 0; d3_out_ready = 0;
      chk("d3.done_pushes", 32'(pushes), 32'd10);
      chk("d3.done_empty",  32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
